rs_multi_issue: RTL
===================

// Module: rs_multi_issue
// PURPOSE
//  Parametrised reservation station for the R10K core; next generation of the single-dispatch RS.
//  - Accepts up to DISPATCH_W renamed instructions per cycle.
//  - Wakes up sources from CDB_W parallel CDB tag broadcasts.
//  - Issues the oldest ready entry per FU type, at most one per type per cycle, gated per type by fu_busy.
//  - Sits between dispatch/rename and the FU issue registers.
// PARAMETERS
//  RS_SIZE       16  number of entries
//  DISPATCH_W     2  dispatch lanes per cycle; lane 0 is program-older than lane 1
//  CDB_W          2  CDB broadcasts per cycle
//  TAG_W          6  phys-reg index width; tag fields are TAG_W+1 bits, MSB = ready
//  FU_W           3  FU-type code width
//  NUM_FU_TYPES   5  issue ports; port t serves entries with fu==t
//  PAYLOAD_W     32  opaque decoded-instruction payload, carried unchanged
// PORTS
//  clock         in   1                           system clock
//  reset         in   1                           asynchronous, active-high
//  enable        in   1                           0 = freeze all state
//  flush         in   1                           synchronous squash of all entries
//  disp_valid    in   DISPATCH_W                  per-lane dispatch request
//  disp_fu       in   DISPATCH_W*FU_W             FU type per lane
//  disp_T        in   DISPATCH_W*(TAG_W+1)        dest tag per lane
//  disp_T1       in   DISPATCH_W*(TAG_W+1)        src1 tag + ready per lane
//  disp_T2       in   DISPATCH_W*(TAG_W+1)        src2 tag + ready per lane
//  disp_payload  in   DISPATCH_W*PAYLOAD_W        payload per lane
//  cdb_valid     in   CDB_W                       broadcast valid
//  cdb_tag       in   CDB_W*TAG_W                 broadcast completed tag
//  fu_busy       in   NUM_FU_TYPES                1 = port t must not issue
//  issue_valid   out  NUM_FU_TYPES                port t carries an issuing entry
//  issue_T/T1/T2 out  NUM_FU_TYPES*(TAG_W+1)      issued entry tags
//  issue_payload out  NUM_FU_TYPES*PAYLOAD_W      issued entry payload
//  free_cnt      out  $clog2(RS_SIZE+1)           invalid entries (registered state)
//  rs_full       out  1                           free_cnt < DISPATCH_W
//  rs_empty      out  1                           free_cnt == RS_SIZE
// BEHAVIOUR
//  Reset (async), state and outputs:
//  - All entries invalid; age matrix cleared.
//  - issue_* = 0, free_cnt = RS_SIZE, rs_full = 0, rs_empty = 1.
//  Dispatch, at posedge, when enable & !flush & !rs_full:
//  - Each valid lane writes the lowest-index free entry; lane 0 takes the lower index.
//  - If rs_full, all lanes are dropped; upstream must hold.
//  - Slots freed by issue this cycle are not reusable until next cycle.
//  Wakeup:
//  - Valid entry with T1/T2 index == any valid cdb_tag sets that ready bit at the edge.
//  - Dispatch bypass: a lane whose src matches a same-cycle cdb_tag is stored ready.
//  - Already-ready sources are unaffected; a tag matching two CDB lanes is treated as one match.
//  Age:
//  - RS_SIZE x RS_SIZE age matrix; a new entry is younger than all valid entries.
//  - Lane 1 is younger than lane 0.
//  Issue select (combinational from registered state):
//  - Port t: oldest valid entry with fu==t and T1,T2 ready, when fu_busy[t]==0 and enable==1.
//  - issue_valid[t] = 1 when such an entry exists; all fields of port t are 0 when issue_valid[t] = 0.
//  - Issued entries are invalidated at the edge.
//  - A CDB wakeup in cycle N makes the entry issue-eligible in cycle N+1.
//  - Minimum dispatch-to-issue latency: 1 cycle.
//  enable = 0:
//  - No dispatch, wakeup or invalidation; CDB ignored; issue_valid = 0.
//  flush = 1 (with enable):
//  - All entries invalid next cycle; dispatch that cycle discarded.
//  - issue outputs remain combinational that cycle.
//  Reset mid-operation clears everything immediately, independent of clock.
//  Invalid FU codes (>= NUM_FU_TYPES) are stored but never issue.
// TESTING
//  1. Reset: assert reset between edges -> same cycle issue_valid = 0, free_cnt = 16, rs_empty = 1, rs_full = 0.
//  2. Dual dispatch + issue:
//     - Stimulus: lane0 ALU T=3 T1=0x41 T2=0x42; lane1 MULT T=4 T1=0x41 T2=0x05.
//     - Next cycle: issue_valid[0] = 1 with T = 3; MULT not issued; free_cnt = 14.
//  3. CDB wakeup:
//     - Stimulus: cdb_valid = 2'b10, cdb_tag[1] = 5.
//     - Next cycle: MULT T = 4 on port 1.
//     - Same-cycle bypass: dispatch src T1 = 0x07 with cdb_tag = 7 -> entry stored ready.
//  4. Age + fu_busy:
//     - Stimulus: three ready LD entries, T = 10, 11, 12 in dispatch order; fu_busy[3] = 1 for 2 cycles.
//     - Response: no issue while busy; then T = 10, 11, 12 on consecutive cycles.
//  5. Full:
//     - Fill to free_cnt = 1 -> rs_full = 1; a 2-lane dispatch is dropped; free_cnt stays 1.
//     - An issue that cycle gives free_cnt = 2 next cycle.
//  6. Flush/enable:
//     - enable = 0 with a CDB hit -> no state change.
//     - flush with dispatch -> free_cnt = 16, rs_empty = 1 next cycle.

Source files
------------

// File: rtl/rs_multi_issue.sv
// Multi-dispatch reservation station: DISPATCH_W-wide allocate, CDB_W-wide wakeup,
// and age-ordered oldest-ready select on each of NUM_FU_TYPES issue ports.

module rs_wakeup #(
  parameter int TAG_W = 6,
  parameter int CDB_W = 2
) (
  input  logic [TAG_W:0]                  tag_in,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]     cdb_tag,
  output logic [TAG_W:0]                  tag_out
);
  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (cdb_valid[c] && (cdb_tag[c] == tag_in[TAG_W-1:0])) hit = 1'b1;
    tag_out = {tag_in[TAG_W] | hit, tag_in[TAG_W-1:0]};
  end
endmodule

module rs_multi_issue #(
  parameter int RS_SIZE      = 16,
  parameter int DISPATCH_W   = 2,
  parameter int CDB_W        = 2,
  parameter int TAG_W        = 6,
  parameter int FU_W         = 3,
  parameter int NUM_FU_TYPES = 5,
  parameter int PAYLOAD_W    = 32,
  localparam int CW          = $clog2(RS_SIZE+1)
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic                                      flush,
  input  logic [DISPATCH_W-1:0]                     disp_valid,
  input  logic [DISPATCH_W-1:0][FU_W-1:0]           disp_fu,
  input  logic [DISPATCH_W-1:0][TAG_W:0]            disp_T,
  input  logic [DISPATCH_W-1:0][TAG_W:0]            disp_T1,
  input  logic [DISPATCH_W-1:0][TAG_W:0]            disp_T2,
  input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]      disp_payload,
  input  logic [CDB_W-1:0]                          cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]               cdb_tag,
  input  logic [NUM_FU_TYPES-1:0]                   fu_busy,
  output logic [NUM_FU_TYPES-1:0]                   issue_valid,
  output logic [NUM_FU_TYPES-1:0][TAG_W:0]          issue_T,
  output logic [NUM_FU_TYPES-1:0][TAG_W:0]          issue_T1,
  output logic [NUM_FU_TYPES-1:0][TAG_W:0]          issue_T2,
  output logic [NUM_FU_TYPES-1:0][PAYLOAD_W-1:0]    issue_payload,
  output logic [CW-1:0]                             free_cnt,
  output logic                                      rs_full,
  output logic                                      rs_empty
);

  logic [RS_SIZE-1:0]                 valid_q, valid_d;
  logic [RS_SIZE-1:0][FU_W-1:0]       fu_q, fu_d;
  logic [RS_SIZE-1:0][TAG_W:0]        t_q, t_d, t1_q, t1_d, t2_q, t2_d;
  logic [RS_SIZE-1:0][PAYLOAD_W-1:0]  pay_q, pay_d;
  // age_q[i][j] = 1 means entry j is older than entry i
  logic [RS_SIZE-1:0][RS_SIZE-1:0]    age_q, age_d;
  logic [CW-1:0]                      free_cnt_q, free_cnt_d;

  logic [RS_SIZE-1:0][TAG_W:0]        e_t1_wk, e_t2_wk;
  logic [DISPATCH_W-1:0][TAG_W:0]     d_t1_wk, d_t2_wk;

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_ent_wk
      rs_wakeup #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_wk1 (
        .tag_in(t1_q[gi]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .tag_out(e_t1_wk[gi]));
      rs_wakeup #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_wk2 (
        .tag_in(t2_q[gi]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .tag_out(e_t2_wk[gi]));
    end
    for (gi = 0; gi < DISPATCH_W; gi++) begin : g_lane_wk
      rs_wakeup #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_wk1 (
        .tag_in(disp_T1[gi]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .tag_out(d_t1_wk[gi]));
      rs_wakeup #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_wk2 (
        .tag_in(disp_T2[gi]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .tag_out(d_t2_wk[gi]));
    end
  endgenerate

  assign free_cnt = free_cnt_q;
  assign rs_full  = free_cnt_q < CW'(DISPATCH_W);
  assign rs_empty = free_cnt_q == CW'(RS_SIZE);

  // Issue select from registered state only.
  logic [RS_SIZE-1:0]                     ready;
  logic [NUM_FU_TYPES-1:0][RS_SIZE-1:0]   cand, sel;
  logic [RS_SIZE-1:0]                     issued;

  always_comb begin
    issue_valid   = '0;
    issue_T       = '0;
    issue_T1      = '0;
    issue_T2      = '0;
    issue_payload = '0;
    issued        = '0;
    cand          = '0;
    sel           = '0;
    for (int i = 0; i < RS_SIZE; i++)
      ready[i] = valid_q[i] & t1_q[i][TAG_W] & t2_q[i][TAG_W];
    for (int t = 0; t < NUM_FU_TYPES; t++) begin
      for (int i = 0; i < RS_SIZE; i++)
        cand[t][i] = ready[i] && (fu_q[i] == FU_W'(t));
      for (int i = 0; i < RS_SIZE; i++)
        sel[t][i] = cand[t][i] && !(|(cand[t] & age_q[i]));
      issue_valid[t] = enable && !fu_busy[t] && (|cand[t]);
      for (int i = 0; i < RS_SIZE; i++) begin
        if (sel[t][i] && issue_valid[t]) begin
          issue_T[t]       = issue_T[t]       | t_q[i];
          issue_T1[t]      = issue_T1[t]      | t1_q[i];
          issue_T2[t]      = issue_T2[t]      | t2_q[i];
          issue_payload[t] = issue_payload[t] | pay_q[i];
          issued[i]        = 1'b1;
        end
      end
    end
  end

  // Lane allocation: each lane claims the lowest still-free slot, lane 0 first.
  logic [DISPATCH_W-1:0][RS_SIZE-1:0] lane_hot;
  logic [RS_SIZE-1:0]                 avail;
  logic                               found;
  logic                               disp_ok;

  always_comb begin
    lane_hot = '0;
    avail    = ~valid_q;
    found    = 1'b0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      found = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (disp_valid[l] && avail[i] && !found) begin
          lane_hot[l][i] = 1'b1;
          avail[i]       = 1'b0;
          found          = 1'b1;
        end
      end
    end
    disp_ok = enable && !flush && !rs_full;
  end

  logic [RS_SIZE-1:0] older_mask;

  always_comb begin
    valid_d    = valid_q;
    fu_d       = fu_q;
    t_d        = t_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    pay_d      = pay_q;
    age_d      = age_q;
    older_mask = valid_q;
    if (enable) begin
      if (flush) begin
        valid_d = '0;
      end else begin
        valid_d = valid_q & ~issued;
        t1_d    = e_t1_wk;
        t2_d    = e_t2_wk;
        if (disp_ok) begin
          for (int l = 0; l < DISPATCH_W; l++) begin
            for (int i = 0; i < RS_SIZE; i++) begin
              if (lane_hot[l][i]) begin
                valid_d[i] = 1'b1;
                fu_d[i]    = disp_fu[l];
                t_d[i]     = disp_T[l];
                t1_d[i]    = d_t1_wk[l];
                t2_d[i]    = d_t2_wk[l];
                pay_d[i]   = disp_payload[l];
                age_d[i]   = older_mask;
                for (int j = 0; j < RS_SIZE; j++) age_d[j][i] = 1'b0;
              end
            end
            older_mask = older_mask | lane_hot[l];
          end
        end
      end
    end
    free_cnt_d = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (!valid_d[i]) free_cnt_d = free_cnt_d + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      fu_q       <= '0;
      t_q        <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      pay_q      <= '0;
      age_q      <= '0;
      free_cnt_q <= CW'(RS_SIZE);
    end else begin
      valid_q    <= valid_d;
      fu_q       <= fu_d;
      t_q        <= t_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      pay_q      <= pay_d;
      age_q      <= age_d;
      free_cnt_q <= free_cnt_d;
    end
  end

endmodule
